// File: rtl/projectile_matrix_bitmap.sv
// Grid of shot cells that scroll one row every FRAMES_PER_STEP frames and are drawn as SHOT_COLOR; RGBout has 1-cycle latency.
// No backpressure: fire requests blocked by cooldown, capacity or an off-grid origin are dropped.
module projectile_matrix_bitmap #(
  parameter int          GRID_COLS       = 32,
  parameter int          GRID_ROWS       = 32,
  parameter int          CELL_W_LOG2     = 5,
  parameter int          CELL_H_LOG2     = 4,
  parameter int          FRAMES_PER_STEP = 2,
  parameter int          DIRECTION       = 0,
  parameter int          MAX_SHOTS       = 4,
  parameter int          COOLDOWN_FRAMES = 8,
  parameter logic [7:0]  SHOT_COLOR      = 8'hD8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] offsetX,
  input  logic [10:0] offsetY,
  input  logic [10:0] originX,
  input  logic [10:0] originY,
  input  logic        fire,
  input  logic        collision,
  input  logic        startOfFrame,
  input  logic        InsideRectangle,
  output logic        drawingRequest,
  output logic [7:0]  RGBout,
  output logic [6:0]  activeShots,
  output logic        fireAccepted
);
  localparam int CW   = $clog2(GRID_COLS);
  localparam int RW   = $clog2(GRID_ROWS);
  localparam int SW   = CELL_W_LOG2 - 1;
  localparam int FC_W = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
  localparam int CD_W = (COOLDOWN_FRAMES > 0) ? $clog2(COOLDOWN_FRAMES + 1) : 1;
  localparam logic [12:0]     X_LIM     = 13'(GRID_COLS << CELL_W_LOG2);
  localparam logic [12:0]     Y_LIM     = 13'(GRID_ROWS << CELL_H_LOG2);
  localparam logic [6:0]      MAX_C     = (MAX_SHOTS > 127) ? 7'd127 : 7'(MAX_SHOTS);
  localparam logic [FC_W-1:0] FC_LAST   = FC_W'(FRAMES_PER_STEP - 1);
  localparam logic [CD_W-1:0] CD_LOAD   = CD_W'(COOLDOWN_FRAMES);
  localparam logic [RW-1:0]   ROW_LAST  = RW'(GRID_ROWS - 1);
  localparam logic [SW-1:0]   SEC_ONES  = '1;
  localparam logic [SW-1:0]   SEC_CLAMP = {{(SW-1){1'b1}}, 1'b0};

  logic [GRID_ROWS-1:0][GRID_COLS-1:0]         en_q;
  logic [GRID_ROWS-1:0][GRID_COLS-1:0][SW-1:0] sec_q;
  logic [FC_W-1:0] fc_q;
  logic [CD_W-1:0] cd_q;
  logic [6:0]      active_q;
  logic            fire_d;
  logic [7:0]      rgb_q;
  logic            fire_acc_q;

  logic [12:0]    px, py, ox, oy;
  logic           pix_in, org_in;
  logic [CW-1:0]  pcol, tcol;
  logic [RW-1:0]  prow, trow;
  logic [SW-1:0]  psec, tsec_raw, tsec;

  assign px       = {2'b00, offsetX};
  assign py       = {2'b00, offsetY};
  assign ox       = {2'b00, originX};
  assign oy       = {2'b00, originY};
  assign pix_in   = (px < X_LIM) && (py < Y_LIM);
  assign org_in   = (ox < X_LIM) && (oy < Y_LIM);
  assign pcol     = px[CELL_W_LOG2 +: CW];
  assign prow     = py[CELL_H_LOG2 +: RW];
  assign tcol     = ox[CELL_W_LOG2 +: CW];
  assign trow     = oy[CELL_H_LOG2 +: RW];
  assign psec     = px[1 +: SW];
  assign tsec_raw = ox[1 +: SW];
  // The all-ones section is never stored, so the rightmost pixel pair of a cell stays clear.
  assign tsec     = (tsec_raw == SEC_ONES) ? SEC_CLAMP : tsec_raw;

  logic                 fire_req, shift, tgt_en, accept, coll_hit, coll_dec, pix_hit;
  logic [GRID_COLS-1:0] depart_row;
  logic [6:0]           depart_cnt, cnt_shift, cnt_next;

  assign fire_req   = fire & ~fire_d;
  assign shift      = startOfFrame && (fc_q == FC_LAST);
  assign depart_row = (DIRECTION == 0) ? en_q[0] : en_q[GRID_ROWS-1];
  assign depart_cnt = 7'($countones(depart_row));

  // Fire target is judged against the grid as it will look after this cycle's shift.
  always_comb begin
    tgt_en = en_q[trow][tcol];
    if (shift) begin
      if (DIRECTION == 0) tgt_en = (trow == ROW_LAST) ? 1'b0 : en_q[trow + 1'b1][tcol];
      else                tgt_en = (trow == '0)       ? 1'b0 : en_q[trow - 1'b1][tcol];
    end
  end

  assign cnt_shift = active_q - (shift ? depart_cnt : 7'd0);
  assign accept    = fire_req && (cd_q == '0) && org_in && ((cnt_shift < MAX_C) || tgt_en);
  assign coll_hit  = collision && !startOfFrame && pix_in && en_q[prow][pcol];
  assign coll_dec  = coll_hit && !(accept && (prow == trow) && (pcol == tcol));
  assign cnt_next  = cnt_shift + {6'd0, accept && !tgt_en} - {6'd0, coll_dec};
  assign pix_hit   = InsideRectangle && pix_in && en_q[prow][pcol] && (sec_q[prow][pcol] == psec);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      en_q       <= '0;
      sec_q      <= '0;
      fc_q       <= '0;
      cd_q       <= '0;
      active_q   <= '0;
      fire_d     <= 1'b1;
      rgb_q      <= 8'hFF;
      fire_acc_q <= 1'b0;
    end else begin
      fire_d     <= fire;
      fire_acc_q <= accept;
      rgb_q      <= pix_hit ? SHOT_COLOR : 8'hFF;
      active_q   <= cnt_next;
      if (startOfFrame) fc_q <= shift ? '0 : fc_q + 1'b1;
      if (accept) cd_q <= CD_LOAD;
      else if (startOfFrame && (cd_q != '0)) cd_q <= cd_q - 1'b1;
      if (shift) begin
        if (DIRECTION == 0) begin
          en_q  <= {{GRID_COLS{1'b0}}, en_q[GRID_ROWS-1:1]};
          sec_q <= {{(GRID_COLS*SW){1'b0}}, sec_q[GRID_ROWS-1:1]};
        end else begin
          en_q  <= {en_q[GRID_ROWS-2:0], {GRID_COLS{1'b0}}};
          sec_q <= {sec_q[GRID_ROWS-2:0], {(GRID_COLS*SW){1'b0}}};
        end
      end
      // Later writes win: a fire on the collided cell re-enables it.
      if (coll_hit) en_q[prow][pcol] <= 1'b0;
      if (accept) begin
        en_q[trow][tcol]  <= 1'b1;
        sec_q[trow][tcol] <= tsec;
      end
    end
  end

  assign RGBout         = rgb_q;
  assign drawingRequest = (rgb_q != 8'hFF);
  assign activeShots    = active_q;
  assign fireAccepted   = fire_acc_q;
endmodule

// File: tb/tb_projectile_matrix_bitmap.sv
// Bench for projectile_matrix_bitmap: three instances (up/cooldown 8, down/cooldown 8, up/no cooldown) share stimulus; each has a shot-list model and a scoreboard.
module tb_projectile_matrix_bitmap;
  localparam int NI = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [10:0] offsetX = '0, offsetY = '0, originX = '0, originY = '0;
  logic        fire = 1'b0, collision = 1'b0, startOfFrame = 1'b0, InsideRectangle = 1'b0;
  int          n_pass = 0, n_total = 0;

  typedef struct {int row; int col; int sec;} shot_t;
  typedef struct {logic [7:0] rgb; bit fa; int act;} exp_t;

  always #5 clk = ~clk;

  generate
    for (genvar g = 0; g < NI; g++) begin : gi
      localparam int DIR = (g == 1) ? 1 : 0;
      localparam int CD  = (g == 2) ? 0 : 8;
      logic [7:0] rgb;
      logic       dr, fa;
      logic [6:0] act;
      int         dut_fa = 0;
      shot_t      shots[$];
      shot_t      moved[$];
      exp_t       q[$];
      int         fc = 0, cd = 0;
      bit         prevf = 1'b1;

      projectile_matrix_bitmap #(.DIRECTION(DIR), .COOLDOWN_FRAMES(CD)) dut (
        .clk(clk), .reset(reset),
        .offsetX(offsetX), .offsetY(offsetY), .originX(originX), .originY(originY),
        .fire(fire), .collision(collision), .startOfFrame(startOfFrame),
        .InsideRectangle(InsideRectangle),
        .drawingRequest(dr), .RGBout(rgb), .activeShots(act), .fireAccepted(fa)
      );

      // Reference: a list of live shots in (row, col, section) grid coordinates.
      initial forever begin : model
        exp_t e;
        bit   req, shift, acc, pin, oin;
        int   prow, pcol, psec, trow, tcol, tsec, tidx, nr;
        @(posedge clk or posedge reset);
        if (reset) begin
          shots.delete(); q.delete();
          fc = 0; cd = 0; prevf = 1'b1;
        end else begin
          pin  = (offsetX < 1024) && (offsetY < 512);
          prow = int'(offsetY) / 16;
          pcol = int'(offsetX) / 32;
          psec = (int'(offsetX) / 2) % 16;
          e.rgb = 8'hFF;
          if (InsideRectangle && pin)
            foreach (shots[i])
              if (shots[i].row == prow && shots[i].col == pcol && shots[i].sec == psec) e.rgb = 8'hD8;
          req   = fire && !prevf;
          prevf = fire;
          shift = startOfFrame && (fc == 1);
          if (startOfFrame) fc = (fc + 1) % 2;
          if (shift) begin
            moved.delete();
            foreach (shots[i]) begin
              nr = shots[i].row + ((DIR == 1) ? 1 : -1);
              if (nr >= 0 && nr < 32) moved.push_back('{nr, shots[i].col, shots[i].sec});
            end
            shots = moved;
          end
          oin  = (originX < 1024) && (originY < 512);
          trow = int'(originY) / 16;
          tcol = int'(originX) / 32;
          tsec = (int'(originX) / 2) % 16;
          if (tsec == 15) tsec = 14;
          tidx = -1;
          foreach (shots[i]) if (shots[i].row == trow && shots[i].col == tcol) tidx = i;
          acc = req && (cd == 0) && oin && (shots.size() < 4 || tidx >= 0);
          if (acc) begin
            if (tidx >= 0) shots[tidx].sec = tsec;
            else shots.push_back('{trow, tcol, tsec});
            cd = CD;
          end else if (startOfFrame && cd > 0) begin
            cd = cd - 1;
          end
          if (collision && !startOfFrame && pin && !(acc && prow == trow && pcol == tcol))
            for (int i = shots.size() - 1; i >= 0; i--)
              if (shots[i].row == prow && shots[i].col == pcol) shots.delete(i);
          e.fa  = acc;
          e.act = shots.size();
          q.push_back(e);
        end
      end

      initial forever begin : mon
        exp_t e;
        @(negedge clk);
        if (!reset && q.size() > 0) begin
          e = q.pop_front();
          n_total++;
          if (rgb === e.rgb && dr === (e.rgb != 8'hFF) && fa === e.fa && act === 7'(e.act))
            n_pass++;
          else
            $display("FAIL scoreboard inst%0d t=%0t rgb=%h want %h dr=%b fa=%b want %b act=%0d want %0d",
                     g, $time, rgb, e.rgb, dr, fa, e.fa, act, e.act);
        end
        if (!reset && fa === 1'b1) dut_fa++;
      end
    end
  endgenerate

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string name, input int got, input int want);
    n_total++;
    if (got == want) n_pass++;
    else $display("FAIL %s: got %0d, want %0d", name, got, want);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(2);
  endtask

  task automatic fire_edge();
    fire = 1'b1;
    tick();
    fire = 1'b0;
    tick(2);
  endtask

  task automatic sof_pulse();
    startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
    tick(3);
  endtask

  int base0, base2;

  initial begin
    // Reset values, with fire held high across reset release.
    fire = 1'b1;
    tick(3);
    chk("rst_rgb0", gi[0].rgb, 8'hFF); chk("rst_dr0", gi[0].dr, 0);
    chk("rst_fa0", gi[0].fa, 0);       chk("rst_act0", gi[0].act, 0);
    chk("rst_rgb1", gi[1].rgb, 8'hFF); chk("rst_act1", gi[1].act, 0);
    chk("rst_rgb2", gi[2].rgb, 8'hFF); chk("rst_act2", gi[2].act, 0);
    reset = 1'b0;
    tick(4);
    fire = 1'b0;
    tick(2);
    chk("held_fire_no_edge", gi[0].dut_fa, 0);

    // Single shot at (row 25, col 3), section 2.
    originX = 11'd100; originY = 11'd400;
    fire = 1'b1;
    tick();
    chk("fa_pulse", gi[0].fa, 1);
    fire = 1'b0;
    tick();
    chk("fa_one_cycle", gi[0].fa, 0);
    chk("act_one", gi[0].act, 1);
    offsetX = 11'd100; offsetY = 11'd400; InsideRectangle = 1'b1;
    tick();
    chk("rgb_shot", gi[0].rgb, 8'hD8);
    chk("dr_shot", gi[0].dr, 1);
    InsideRectangle = 1'b0;
    tick();

    // Cooldown: held fire gives one shot; early edge rejected; edge after 8 frames accepted.
    repeat (8) sof_pulse();
    base0 = gi[0].dut_fa;
    originX = 11'd300; originY = 11'd200;
    fire = 1'b1;
    tick(1000);
    fire = 1'b0;
    tick(2);
    chk("held_one_shot", gi[0].dut_fa - base0, 1);
    base0 = gi[0].dut_fa;
    fire_edge();
    chk("cooldown_reject", gi[0].dut_fa - base0, 0);
    repeat (8) sof_pulse();
    base0 = gi[0].dut_fa;
    fire_edge();
    chk("cooldown_expired", gi[0].dut_fa - base0, 1);

    // Capacity limit with no cooldown.
    do_reset();
    base0 = gi[0].dut_fa; base2 = gi[2].dut_fa;
    originY = 11'd100;
    for (int c = 0; c < 5; c++) begin
      originX = 11'(c * 32 + 10);
      fire_edge();
    end
    chk("cap_accepts", gi[2].dut_fa - base2, 4);
    chk("cap_act", gi[2].act, 4);
    chk("cap_cooldown_inst0", gi[0].dut_fa - base0, 1);

    // Shots leave through the edge row.
    do_reset();
    originX = 11'd50; originY = 11'd5;
    fire_edge();
    chk("row0_act", gi[0].act, 1);
    sof_pulse(); sof_pulse();
    chk("row0_leaves_up", gi[0].act, 0);
    do_reset();
    originY = 11'd499;
    fire_edge();
    chk("row31_act", gi[1].act, 1);
    sof_pulse(); sof_pulse();
    chk("row31_leaves_down", gi[1].act, 0);

    // Collision removes the shot.
    do_reset();
    originX = 11'd100; originY = 11'd400;
    fire_edge();
    offsetX = 11'd100; offsetY = 11'd400; InsideRectangle = 1'b1; collision = 1'b1;
    tick();
    chk("coll_act", gi[0].act, 0);
    collision = 1'b0;
    tick();
    chk("coll_rgb_clear", gi[0].rgb, 8'hFF);
    InsideRectangle = 1'b0;

    // Randomised traffic.
    for (int i = 0; i < 3000; i++) begin
      fire            = ($urandom_range(0, 3) == 0);
      startOfFrame    = ($urandom_range(0, 15) == 0);
      collision       = ($urandom_range(0, 5) == 0);
      InsideRectangle = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) begin
        originX = 11'($urandom_range(0, 1100));
        originY = 11'($urandom_range(0, 560));
      end
      if ($urandom_range(0, 1) == 0) begin
        offsetX = originX + 11'($urandom_range(0, 3));
        offsetY = originY;
      end else begin
        offsetX = 11'($urandom_range(0, 1100));
        offsetY = 11'($urandom_range(0, 560));
      end
      tick();
    end
    fire = 1'b0; collision = 1'b0; startOfFrame = 1'b0; InsideRectangle = 1'b0;
    tick(2);

    // Reset mid-frame with a shot on screen.
    do_reset();
    originX = 11'd100; originY = 11'd400;
    fire_edge();
    sof_pulse();
    offsetX = 11'd100; offsetY = 11'd400; InsideRectangle = 1'b1;
    tick();
    chk("pre_reset_rgb", gi[0].rgb, 8'hD8);
    chk("pre_reset_act", gi[0].act, 1);
    reset = 1'b1;
    #1;
    chk("async_rst_rgb", gi[0].rgb, 8'hFF);
    chk("async_rst_dr", gi[0].dr, 0);
    chk("async_rst_act", gi[0].act, 0);
    chk("async_rst_fa", gi[0].fa, 0);
    InsideRectangle = 1'b0;
    tick(2);
    reset = 1'b0;
    tick(3);
    chk("post_reset_act", gi[0].act, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/projectile_matrix_bitmap.md
PROJECTILE_MATRIX_BITMAP -- requirements
Module: projectile_matrix_bitmap

Interface
REQ-001 The block SHALL have these parameters, one per line: name, default, meaning.
- GRID_COLS, 32, cell columns (power of 2, 2..64).
- GRID_ROWS, 32, cell rows (power of 2, 2..64).
- CELL_W_LOG2, 5, log2 of cell width in pixels (3..6).
- CELL_H_LOG2, 4, log2 of cell height in pixels (2..6).
- FRAMES_PER_STEP, 2, frames between one-row shifts (>=1).
- DIRECTION, 0, 0 = shots move up (player); 1 = shots move down (monster).
- MAX_SHOTS, 4, maximum simultaneously enabled cells (1..GRID_COLS*GRID_ROWS).
- COOLDOWN_FRAMES, 8, frames after an accepted shot during which fire is rejected (0 = none).
- SHOT_COLOR, 8'hD8, RGB332 shot color; must not equal 8'hFF.
REQ-002 The block SHALL have these ports, one per line: name, direction, width, meaning.
- clk, input, 1, system clock.
- reset, input, 1, asynchronous active-high reset.
- offsetX, input, 11, VGA pixel X relative to matrix top-left.
- offsetY, input, 11, VGA pixel Y relative to matrix top-left.
- originX, input, 11, shooter muzzle X relative to matrix top-left.
- originY, input, 11, shooter muzzle Y relative to matrix top-left.
- fire, input, 1, shoot request level.
- collision, input, 1, current pixel of this block hit an object.
- startOfFrame, input, 1, one-cycle pulse per frame.
- InsideRectangle, input, 1, current pixel is inside the matrix area.
- drawingRequest, output, 1, pixel is opaque.
- RGBout, output, 8, pixel color, 8'hFF = transparent.
- activeShots, output, 7, number of enabled cells.
- fireAccepted, output, 1, one-cycle pulse when a shot is created.

Function
REQ-003 Each cell SHALL hold an enable bit and a section field of CELL_W_LOG2-1 bits.
- Cell index: row = Y[CELL_H_LOG2+5:CELL_H_LOG2], col = X[CELL_W_LOG2+5:CELL_W_LOG2], both truncated to grid size.
- Coordinates outside the grid SHALL be ignored for both writes and reads.
REQ-004 Section SHALL be X[CELL_W_LOG2-1:1].
- At fire, the all-ones section SHALL be stored as all-ones minus 1.
REQ-005 Fire SHALL be rising-edge detected: a registered copy of fire, with a request when fire=1 and the previous value=0.
REQ-006 A request SHALL be accepted only when all of the following hold:
- cooldown counter = 0;
- activeShots < MAX_SHOTS, or the target cell is already enabled;
- the origin is inside the grid.
- Rejected requests SHALL be dropped, not queued.
REQ-007 On acceptance the block SHALL:
- write the target cell enable=1 and set its section;
- pulse fireAccepted for exactly 1 cycle, in the cycle after the edge;
- load the cooldown counter with COOLDOWN_FRAMES;
- increment activeShots only if the cell was previously disabled.
REQ-008 The cooldown counter SHALL decrement by 1 on each startOfFrame while nonzero.
REQ-009 A frame counter SHALL count startOfFrame pulses from 0 to FRAMES_PER_STEP-1; on the pulse at FRAMES_PER_STEP-1 it SHALL wrap to 0 and shift the grid by one row.
- DIRECTION=0: row r takes row r+1, and the last row is cleared.
- DIRECTION=1: row r takes row r-1, and row 0 is cleared.
REQ-010 On a shift, activeShots SHALL decrease by the popcount of the enables in the departing edge row (row 0 when DIRECTION=0, the last row when DIRECTION=1).
REQ-011 When collision=1 and the addressed cell is enabled, that cell SHALL be disabled and activeShots decremented, in the same clock edge.
REQ-012 Simultaneous events SHALL be handled as follows:
- accepted fire and shift in the same cycle: the shift applies first, then the fire write is made at post-shift coordinates;
- collision coinciding with startOfFrame: the collision is ignored;
- collision and accepted fire on the same cell: the fire wins.
- activeShots SHALL never underflow or exceed MAX_SHOTS.
REQ-013 RGBout SHALL be registered with 1-cycle latency.
- RGBout = SHOT_COLOR when InsideRectangle=1, the addressed cell is enabled and its section equals the pixel section.
- Otherwise RGBout = 8'hFF.
REQ-014 drawingRequest SHALL be combinational: drawingRequest = (RGBout != 8'hFF).

Reset
REQ-015 While reset=1, asynchronously:
- all cells SHALL be disabled;
- the frame counter, the cooldown counter and activeShots SHALL be 0;
- RGBout SHALL be 8'hFF, and drawingRequest and fireAccepted SHALL be 0;
- the fire history register SHALL be 1, so a fire held high through reset release is not taken as an edge.
REQ-016 Reset asserted mid-frame or mid-cooldown SHALL discard all shots; no shot state survives reset.

Verification
REQ-017 Defaults, originX=100, originY=400, fire pulse:
- cell (25,3) enabled with section 2, fireAccepted is 1 cycle, activeShots=1;
- at offsetX=100, offsetY=400, inside=1, RGBout=8'hD8 one cycle later.
REQ-018 Fire held high for 1000 cycles -> exactly one shot is created.
- Second edge within 8 frames -> rejected.
- Edge after 8 startOfFrame pulses -> accepted.
REQ-019 COOLDOWN_FRAMES=0, five fire edges at different columns -> 4 shots are accepted, the fifth is rejected, activeShots=4.
REQ-020 Shot in row 0, DIRECTION=0, 2 startOfFrame pulses -> the shot leaves, activeShots=0.
- DIRECTION=1, shot in row 31 -> the same outcome.
REQ-021 collision=1 on a drawn shot pixel -> the cell is disabled, the next RGBout=8'hFF, activeShots decrements.
- Assert reset mid-frame -> all outputs return to their reset values immediately.
